// File: rtl/serial_receiver_if.sv
// Serial receiver bus: the RX line, the downstream FIFO handshake, and status flags.
// master = receiver side, slave = line driver / FIFO / status consumer.
interface serial_receiver_if;
  logic       RX;
  logic       full;
  logic       overrun_clr;
  logic [7:0] dout;
  logic       dout_valid;
  logic       frame_err;
  logic       overrun;

  modport master (
    input  RX, full, overrun_clr,
    output dout, dout_valid, frame_err, overrun
  );

  modport slave (
    output RX, full, overrun_clr,
    input  dout, dout_valid, frame_err, overrun
  );
endinterface

// File: rtl/serial_receiver.sv
// UART 8N1 receiver: recovers LSB-first bytes from RX and emits one-cycle FIFO write strobes.
// The stop bit is sampled at mid-bit, so back-to-back frames need no idle gap.
module serial_receiver #(
  parameter int CLK_IN     = 0,
  parameter int BAUD       = 0,
  parameter int BIT_PERIOD = CLK_IN / BAUD,
  parameter int HALF       = BIT_PERIOD / 2
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_receiver_if.master   bus
);

  if (BIT_PERIOD < 4 || BIT_PERIOD > 65535) begin : g_bad_bit_period
    $error("serial_receiver: BIT_PERIOD must be within 4..65535");
  end

  localparam logic [15:0] HALF_LAST = 16'(HALF - 1);
  localparam logic [15:0] BIT_LAST  = 16'(BIT_PERIOD - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  sr_q, sr_d;
  logic [7:0]  dout_q, dout_d;
  logic        dout_valid_q, dout_valid_d;
  logic        frame_err_q, frame_err_d;
  logic        overrun_q, overrun_d;
  logic        rx_meta_q, rx_meta_d;
  logic        rx_s_q, rx_s_d;
  logic        drop_s;

  // Next-state, datapath and strobe computation.
  always_comb begin
    rx_meta_d    = bus.RX;
    rx_s_d       = rx_meta_q;
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    sr_d         = sr_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    drop_s       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d = S_START;
          cnt_d   = 16'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          if (!rx_s_q) begin
            state_d = S_DATA;
            cnt_d   = 16'd0;
            idx_d   = 3'd0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          sr_d  = {rx_s_q, sr_q[7:1]};
          cnt_d = 16'd0;
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = 16'd0;
          if (rx_s_q) begin
            state_d = S_IDLE;
            if (bus.full) begin
              drop_s = 1'b1;
            end else begin
              dout_d       = sr_q;
              dout_valid_d = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_BREAK: begin
        if (rx_s_q) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_BREAK;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // A drop on the same edge as a clear keeps the flag set.
    if (drop_s) begin
      overrun_d = 1'b1;
    end else if (bus.overrun_clr) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      state_q      <= S_IDLE;
      cnt_q        <= 16'd0;
      idx_q        <= 3'd0;
      sr_q         <= 8'd0;
      dout_q       <= 8'd0;
      dout_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      rx_meta_q    <= rx_meta_d;
      rx_s_q       <= rx_s_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      sr_q         <= sr_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.overrun    = overrun_q;

endmodule
